// File: rtl/mem_trace_serializer_if.sv
// Bus bundle for mem_trace_serializer: the per-lane capture vector on the input
// side and the one-record-per-beat valid/ready drain on the output side.
interface mem_trace_serializer_if #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int SIZE_W    = 32,
    parameter int TS_W      = 64
);
    localparam int TID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [NUM_LANES-1:0]        in_valid;
    logic [ADDR_W*NUM_LANES-1:0] in_address;
    logic [NUM_LANES-1:0]        in_is_store;
    logic [SIZE_W*NUM_LANES-1:0] in_size;
    logic [DATA_W*NUM_LANES-1:0] in_data;
    logic                        in_ready;

    logic                        out_valid;
    logic                        out_ready;
    logic [TS_W-1:0]             out_cycle;
    logic [TID_W-1:0]            out_tid;
    logic [ADDR_W-1:0]           out_address;
    logic                        out_is_store;
    logic [SIZE_W-1:0]           out_size;
    logic [DATA_W-1:0]           out_data;
    logic                        out_last;

    // Producer of capture vectors and consumer of trace records.
    modport master (
        output in_valid, in_address, in_is_store, in_size, in_data, out_ready,
        input  in_ready, out_valid, out_cycle, out_tid, out_address,
               out_is_store, out_size, out_data, out_last
    );

    // The serializer itself.
    modport slave (
        input  in_valid, in_address, in_is_store, in_size, in_data, out_ready,
        output in_ready, out_valid, out_cycle, out_tid, out_address,
               out_is_store, out_size, out_data, out_last
    );
endinterface

// File: rtl/mem_trace_serializer.sv
// Multi-lane memory-trace capture FIFO that drains one lane record per beat.
// Define MEM_TRACE_SERIALIZER_DROP_EN to never back-pressure and count dropped vectors instead.
module mem_trace_serializer #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int SIZE_W    = 32,
    parameter int DEPTH     = 8,
    parameter int TS_W      = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    mem_trace_serializer_if.slave    bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              drop_count
);
    localparam int TID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage, one full lane vector per slot.
    logic [NUM_LANES-1:0]        mask_mem  [DEPTH];
    logic [ADDR_W*NUM_LANES-1:0] addr_mem  [DEPTH];
    logic [NUM_LANES-1:0]        store_mem [DEPTH];
    logic [SIZE_W*NUM_LANES-1:0] size_mem  [DEPTH];
    logic [DATA_W*NUM_LANES-1:0] data_mem  [DEPTH];
    logic [TS_W-1:0]             ts_mem    [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic [NUM_LANES-1:0] done_q,   done_d;
    logic [TS_W-1:0]      cycle_q,  cycle_d;

    logic                 offered;
    logic                 full;
    logic                 push;
    logic                 out_fire;
    logic                 pop;
    logic                 head_valid;
    logic [NUM_LANES-1:0] work_mask;
    logic [NUM_LANES-1:0] lane_bit;
    logic [TID_W-1:0]     head_tid;
    logic                 head_last;

    logic [ADDR_W-1:0]    lane_addr  [NUM_LANES];
    logic [SIZE_W-1:0]    lane_size  [NUM_LANES];
    logic [DATA_W-1:0]    lane_data  [NUM_LANES];
    logic                 lane_store [NUM_LANES];

    assign offered    = (bus.in_valid != '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign push       = offered && !full;
    assign head_valid = (count_q != '0);

    // The working mask is the stored mask minus lanes already sent, so a new
    // head is "loaded" simply by clearing done_q on the popping edge.
    assign work_mask = mask_mem[rd_ptr_q] & ~done_q;
    assign lane_bit  = work_mask & (~work_mask + NUM_LANES'(1));
    assign head_last = ((work_mask & (work_mask - NUM_LANES'(1))) == '0);
    assign out_fire  = head_valid && bus.out_ready;
    assign pop       = out_fire && head_last;

    always_comb begin
        head_tid = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (work_mask[i]) begin
                head_tid = TID_W'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_addr[gi]  = addr_mem[rd_ptr_q][ADDR_W*gi +: ADDR_W];
            assign lane_size[gi]  = size_mem[rd_ptr_q][SIZE_W*gi +: SIZE_W];
            assign lane_data[gi]  = data_mem[rd_ptr_q][DATA_W*gi +: DATA_W];
            assign lane_store[gi] = store_mem[rd_ptr_q][gi];
        end
    endgenerate

    always_comb begin
        cycle_d  = cycle_q + TS_W'(1);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = done_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (out_fire) begin
            if (head_last) begin
                done_d   = '0;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                done_d = done_q | lane_bit;
            end
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= '0;
            count_q  <= '0;
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mask_mem[wr_ptr_q]  <= bus.in_valid;
            addr_mem[wr_ptr_q]  <= bus.in_address;
            store_mem[wr_ptr_q] <= bus.in_is_store;
            size_mem[wr_ptr_q]  <= bus.in_size;
            data_mem[wr_ptr_q]  <= bus.in_data;
            ts_mem[wr_ptr_q]    <= cycle_q;
        end
    end

    assign bus.out_valid    = head_valid;
    assign bus.out_cycle    = ts_mem[rd_ptr_q];
    assign bus.out_tid      = head_tid;
    assign bus.out_address  = lane_addr[head_tid];
    assign bus.out_is_store = lane_store[head_tid];
    assign bus.out_size     = lane_size[head_tid];
    assign bus.out_data     = lane_data[head_tid];
    assign bus.out_last     = head_last;
    assign occupancy        = count_q;

`ifdef MEM_TRACE_SERIALIZER_DROP_EN
    logic [31:0] drop_q, drop_d;

    // Saturating count of vectors discarded because every slot was taken.
    always_comb begin
        drop_d = drop_q;
        if (offered && full && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count   = drop_q;
    assign bus.in_ready = 1'b1;
`else
    assign drop_count   = '0;
    assign bus.in_ready = !full;
`endif

endmodule

// File: tb/tb_mem_trace_serializer.sv
// Randomized self-checking bench for mem_trace_serializer against a queue-of-vectors model.
// Honours MEM_TRACE_SERIALIZER_DROP_EN when the design is built with it.
module tb_mem_trace_serializer;
    localparam int NL    = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int SW    = 32;
    localparam int DEPTH = 8;
    localparam int TSW   = 64;

`ifdef MEM_TRACE_SERIALIZER_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct {
        logic [NL-1:0]    rem;
        logic [NL*AW-1:0] addr;
        logic [NL-1:0]    st;
        logic [NL*SW-1:0] sz;
        logic [NL*DW-1:0] data;
        logic [TSW-1:0]   ts;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0]            drop_count;

    int n_tests;
    int n_fail;

    vec_t           mq[$];
    logic [TSW-1:0] m_cyc;
    int unsigned    m_drops;

    mem_trace_serializer_if #(
        .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TS_W(TSW)
    ) bus ();

    mem_trace_serializer #(
        .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .DEPTH(DEPTH), .TS_W(TSW)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .bus        (bus),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [NL-1:0] m);
        for (int i = 0; i < NL; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic compare_all();
        int   sz;
        int   ln;
        vec_t h;
        sz = mq.size();
        check("out_valid",  64'(bus.out_valid), 64'(sz != 0));
        check("occupancy",  64'(occupancy), 64'(sz));
        check("in_ready",   64'(bus.in_ready), 64'(DROP_EN || (sz != DEPTH)));
        check("drop_count", 64'(drop_count), 64'(m_drops));
        if (sz != 0) begin
            h  = mq[0];
            ln = lowest(h.rem);
            check("out_tid",      64'(bus.out_tid), 64'(ln));
            check("out_cycle",    64'(bus.out_cycle), 64'(h.ts));
            check("out_address",  64'(bus.out_address), 64'(h.addr[ln*AW +: AW]));
            check("out_is_store", 64'(bus.out_is_store), 64'(h.st[ln]));
            check("out_size",     64'(bus.out_size), 64'(h.sz[ln*SW +: SW]));
            check("out_data",     64'(bus.out_data), 64'(h.data[ln*DW +: DW]));
            check("out_last",     64'(bus.out_last), 64'($countones(h.rem) == 1));
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then compare.
    task automatic tick(input logic [NL-1:0] mask, input bit rdy);
        vec_t v;
        vec_t h;
        int   sz;
        int   ln;
        bus.in_valid  = mask;
        bus.out_ready = rdy;
        for (int l = 0; l < NL; l++) begin
            bus.in_address[l*AW +: AW] = {$urandom, $urandom};
            bus.in_size[l*SW +: SW]    = $urandom;
            bus.in_data[l*DW +: DW]    = {$urandom, $urandom};
        end
        bus.in_is_store = NL'($urandom);

        v.rem  = mask;
        v.addr = bus.in_address;
        v.st   = bus.in_is_store;
        v.sz   = bus.in_size;
        v.data = bus.in_data;
        v.ts   = m_cyc;

        sz = mq.size();
        if (sz != 0 && rdy) begin
            h  = mq[0];
            ln = lowest(h.rem);
            $display("[TB] record tid=%0d cycle=%0d addr=0x%0h last=%0d",
                     ln, h.ts, h.addr[ln*AW +: AW], $countones(h.rem) == 1);
            h.rem[ln] = 1'b0;
            if (h.rem == '0) void'(mq.pop_front());
            else mq[0] = h;
        end
        if (mask != '0) begin
            if (sz != DEPTH) mq.push_back(v);
            else if (DROP_EN && m_drops != 32'hFFFF_FFFF) m_drops++;
        end
        m_cyc = m_cyc + TSW'(1);

        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_cyc   = '0;
        m_drops = 0;
        compare_all();
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        m_cyc           = '0;
        m_drops         = 0;
        bus.in_valid    = '0;
        bus.in_address  = '0;
        bus.in_is_store = '0;
        bus.in_size     = '0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;

        do_reset();

        // Single vector 1010 stamped at counter 5.
        repeat (5) tick('0, 1'b1);
        tick(4'b1010, 1'b1);
        check("tp1_tid_a",   64'(bus.out_tid), 64'd1);
        check("tp1_cycle",   64'(bus.out_cycle), 64'd5);
        check("tp1_last_a",  64'(bus.out_last), 64'd0);
        tick('0, 1'b1);
        check("tp1_tid_b",   64'(bus.out_tid), 64'd3);
        check("tp1_last_b",  64'(bus.out_last), 64'd1);
        check("tp1_occ_b",   64'(occupancy), 64'd1);
        tick('0, 1'b1);
        check("tp1_occ_end", 64'(occupancy), 64'd0);

        // Idle mask never enqueues.
        repeat (10) tick('0, 1'($urandom_range(0, 1)));
        check("idle_valid", 64'(bus.out_valid), 64'd0);
        check("idle_occ",   64'(occupancy), 64'd0);

        // Fill to DEPTH with the sink stalled, then drain 32 back-to-back records.
        repeat (DEPTH) tick(4'b1111, 1'b0);
        check("fill_occ",   64'(occupancy), 64'(DEPTH));
        check("fill_ready", 64'(bus.in_ready), 64'(DROP_EN));
        tick(4'b1111, 1'b0);
        repeat (NL * DEPTH) tick('0, 1'b1);
        check("drain_occ",  64'(occupancy), 64'd0);

        // Full FIFO, final record pops while a vector is offered.
        repeat (DEPTH) tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b1);
        check("fp_occ_pop",  64'(occupancy), 64'(DEPTH - 1));
        check("fp_ready",    64'(bus.in_ready), 64'd1);
        tick(4'b0010, 1'b0);
        check("fp_occ_full", 64'(occupancy), 64'(DEPTH));
        repeat (DEPTH * NL + 4) tick('0, 1'b1);

`ifdef MEM_TRACE_SERIALIZER_DROP_EN
        do_reset();
        repeat (DEPTH) tick(4'b0110, 1'b0);
        repeat (3) tick(4'b1001, 1'b0);
        check("drop_cnt3",  64'(drop_count), 64'd3);
        check("drop_ready", 64'(bus.in_ready), 64'd1);
        repeat (DEPTH * 2 + 2) tick('0, 1'b1);
`endif

        // Randomized traffic with the sink's acceptance rate varying per segment.
        for (int seg = 0; seg < 8; seg++) begin
            int p;
            p = seg % 5;
            repeat (200) begin
                logic [NL-1:0] m;
                m = ($urandom_range(0, 3) == 0) ? NL'(0) : NL'($urandom);
                tick(m, $urandom_range(0, 3) < p);
            end
        end
        repeat (DEPTH * NL + 4) tick('0, 1'b1);

        // Reset in the middle of a vector's drain flushes everything.
        tick(4'b1111, 1'b0);
        tick('0, 1'b1);
        tick('0, 1'b1);
        check("mid_tid", 64'(bus.out_tid), 64'd2);
        do_reset();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_occ",   64'(occupancy), 64'd0);
        tick(4'b0100, 1'b0);
        check("rst_cycle", 64'(bus.out_cycle), 64'd0);
        check("rst_tid",   64'(bus.out_tid), 64'd2);
        repeat (4) tick('0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
